// File: rtl/cyclotron_ibuf_pkg.sv
// Shared types for the Cyclotron per-warp instruction buffer.
// Holds the decoded trace entry layout and a helper that builds one from port slices.
package cyclotron_ibuf_pkg;

    localparam int ARCH_LEN  = 32;
    localparam int OP_BITS   = 7;
    localparam int REG_BITS  = 8;
    localparam int IMM_BITS  = 32;
    localparam int PRED_BITS = 4;

    typedef struct packed {
        logic [ARCH_LEN-1:0]  pc;
        logic [OP_BITS-1:0]   op;
        logic [REG_BITS-1:0]  rd;
        logic [REG_BITS-1:0]  rs1;
        logic [REG_BITS-1:0]  rs2;
        logic [IMM_BITS-1:0]  imm;
        logic [PRED_BITS-1:0] pred;
    } ibuf_entry_t;

    localparam int ENTRY_BITS = $bits(ibuf_entry_t);

    function automatic ibuf_entry_t pack_entry(
        input logic [ARCH_LEN-1:0]  pc,
        input logic [OP_BITS-1:0]   op,
        input logic [REG_BITS-1:0]  rd,
        input logic [REG_BITS-1:0]  rs1,
        input logic [REG_BITS-1:0]  rs2,
        input logic [IMM_BITS-1:0]  imm,
        input logic [PRED_BITS-1:0] pred
    );
        ibuf_entry_t e;
        e.pc   = pc;
        e.op   = op;
        e.rd   = rd;
        e.rs1  = rs1;
        e.rs2  = rs2;
        e.imm  = imm;
        e.pred = pred;
        return e;
    endfunction

endpackage

// File: rtl/cyclotron_ibuf_fifo.sv
// Single-warp instruction FIFO with flush and an occupancy count.
// Full/empty come from the count, so the pointers just wrap.
module cyclotron_ibuf_fifo
    import cyclotron_ibuf_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  ibuf_entry_t         in_entry,
    output logic                out_valid,
    input  logic                out_ready,
    output ibuf_entry_t         out_entry,
    output logic [CNT_BITS-1:0] count,
    output logic [CNT_BITS-1:0] count_next
);
    localparam int PTR_BITS = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("cyclotron_ibuf_fifo: DEPTH must be a power of two >= 2");
    end

    ibuf_entry_t         mem_q [DEPTH];
    logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                enq, deq;

    // Outputs are forced idle while reset is held, before the state clears.
    assign in_ready   = !flush && (reset || count_q < CNT_BITS'(DEPTH));
    assign out_valid  = !reset && !flush && count_q != '0;
    assign out_entry  = mem_q[head_q];
    assign enq        = in_valid && in_ready && !reset;
    assign deq        = out_valid && out_ready;
    assign count      = count_q;
    assign count_next = count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_BITS'(1);
            if (deq) head_d = head_q + PTR_BITS'(1);
            if (enq && !deq)      count_d = count_q + CNT_BITS'(1);
            else if (deq && !enq) count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) mem_q[tail_q] <= in_entry;
    end

    a_no_enq_full: assert property (@(posedge clock) disable iff (reset)
        !(enq && count_q == CNT_BITS'(DEPTH)));
    a_no_deq_empty: assert property (@(posedge clock) disable iff (reset)
        !(deq && count_q == '0));

endmodule

// File: rtl/cyclotron_ibuf_frontend.sv
// Per-warp instruction buffer between the Cyclotron trace source and issue.
// Flattens/unflattens the per-warp port slices and tracks drained-aware finish.
module cyclotron_ibuf_frontend
    import cyclotron_ibuf_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_WARPS-1:0]            src_valid,
    output logic [NUM_WARPS-1:0]            src_ready,
    input  logic [ARCH_LEN*NUM_WARPS-1:0]   src_pc,
    input  logic [OP_BITS*NUM_WARPS-1:0]    src_op,
    input  logic [REG_BITS*NUM_WARPS-1:0]   src_rd,
    input  logic [REG_BITS*NUM_WARPS-1:0]   src_rs1,
    input  logic [REG_BITS*NUM_WARPS-1:0]   src_rs2,
    input  logic [IMM_BITS*NUM_WARPS-1:0]   src_imm,
    input  logic [PRED_BITS*NUM_WARPS-1:0]  src_pred,
    input  logic                            src_finished,
    output logic [NUM_WARPS-1:0]            ibuf_valid,
    input  logic [NUM_WARPS-1:0]            ibuf_ready,
    output logic [ARCH_LEN*NUM_WARPS-1:0]   ibuf_pc,
    output logic [OP_BITS*NUM_WARPS-1:0]    ibuf_op,
    output logic [REG_BITS*NUM_WARPS-1:0]   ibuf_rd,
    output logic [REG_BITS*NUM_WARPS-1:0]   ibuf_rs1,
    output logic [REG_BITS*NUM_WARPS-1:0]   ibuf_rs2,
    output logic [IMM_BITS*NUM_WARPS-1:0]   ibuf_imm,
    output logic [PRED_BITS*NUM_WARPS-1:0]  ibuf_pred,
    input  logic [NUM_WARPS-1:0]            flush,
    output logic [CNT_BITS*NUM_WARPS-1:0]   occupancy,
    output logic                            finished
);
    logic [NUM_WARPS-1:0][CNT_BITS-1:0] count_next;
    logic finished_seen_q, finished_seen_d;
    logic finished_q, finished_d;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        ibuf_entry_t in_e, out_e;

        assign in_e = pack_entry(src_pc  [ARCH_LEN*w  +: ARCH_LEN],
                                 src_op  [OP_BITS*w   +: OP_BITS],
                                 src_rd  [REG_BITS*w  +: REG_BITS],
                                 src_rs1 [REG_BITS*w  +: REG_BITS],
                                 src_rs2 [REG_BITS*w  +: REG_BITS],
                                 src_imm [IMM_BITS*w  +: IMM_BITS],
                                 src_pred[PRED_BITS*w +: PRED_BITS]);

        cyclotron_ibuf_fifo #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush[w]),
            .in_valid   (src_valid[w]),
            .in_ready   (src_ready[w]),
            .in_entry   (in_e),
            .out_valid  (ibuf_valid[w]),
            .out_ready  (ibuf_ready[w]),
            .out_entry  (out_e),
            .count      (occupancy[CNT_BITS*w +: CNT_BITS]),
            .count_next (count_next[w])
        );

        assign ibuf_pc  [ARCH_LEN*w  +: ARCH_LEN]  = out_e.pc;
        assign ibuf_op  [OP_BITS*w   +: OP_BITS]   = out_e.op;
        assign ibuf_rd  [REG_BITS*w  +: REG_BITS]  = out_e.rd;
        assign ibuf_rs1 [REG_BITS*w  +: REG_BITS]  = out_e.rs1;
        assign ibuf_rs2 [REG_BITS*w  +: REG_BITS]  = out_e.rs2;
        assign ibuf_imm [IMM_BITS*w  +: IMM_BITS]  = out_e.imm;
        assign ibuf_pred[PRED_BITS*w +: PRED_BITS] = out_e.pred;
    end

    // Finish waits until every FIFO has drained after the source is exhausted.
    always_comb begin
        finished_seen_d = finished_seen_q || src_finished;
        finished_d      = finished_q || (finished_seen_d && count_next == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            finished_seen_q <= 1'b0;
            finished_q      <= 1'b0;
        end else begin
            finished_seen_q <= finished_seen_d;
            finished_q      <= finished_d;
        end
    end

    assign finished = finished_q;

    a_no_valid_after_finish: assert property (@(posedge clock) disable iff (reset)
        !(finished_q && |src_valid));

endmodule

// File: tb/tb_cyclotron_ibuf_frontend.sv
// Bench for cyclotron_ibuf_frontend: vector table, directed corner sequences,
// and randomized traffic checked against per-warp queue model.
`timescale 1ns/1ps
module tb_cyclotron_ibuf_frontend;
    import cyclotron_ibuf_pkg::*;

    localparam int NW    = 8;
    localparam int DEPTH = 4;
    localparam int CB    = $clog2(DEPTH + 1);

    logic clock = 1'b0;
    logic reset;
    logic [NW-1:0] src_valid, src_ready, ibuf_valid, ibuf_ready, flush;
    logic src_finished, finished;
    logic [ARCH_LEN*NW-1:0]  src_pc,   ibuf_pc;
    logic [OP_BITS*NW-1:0]   src_op,   ibuf_op;
    logic [REG_BITS*NW-1:0]  src_rd,   ibuf_rd, src_rs1, ibuf_rs1, src_rs2, ibuf_rs2;
    logic [IMM_BITS*NW-1:0]  src_imm,  ibuf_imm;
    logic [PRED_BITS*NW-1:0] src_pred, ibuf_pred;
    logic [CB*NW-1:0]        occupancy;

    ibuf_entry_t in_e [NW];

    always #5 clock = ~clock;

    for (genvar w = 0; w < NW; w++) begin : g_flat
        assign src_pc  [ARCH_LEN*w  +: ARCH_LEN]  = in_e[w].pc;
        assign src_op  [OP_BITS*w   +: OP_BITS]   = in_e[w].op;
        assign src_rd  [REG_BITS*w  +: REG_BITS]  = in_e[w].rd;
        assign src_rs1 [REG_BITS*w  +: REG_BITS]  = in_e[w].rs1;
        assign src_rs2 [REG_BITS*w  +: REG_BITS]  = in_e[w].rs2;
        assign src_imm [IMM_BITS*w  +: IMM_BITS]  = in_e[w].imm;
        assign src_pred[PRED_BITS*w +: PRED_BITS] = in_e[w].pred;
    end

    cyclotron_ibuf_frontend #(.NUM_WARPS(NW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pc(src_pc), .src_op(src_op), .src_rd(src_rd), .src_rs1(src_rs1),
        .src_rs2(src_rs2), .src_imm(src_imm), .src_pred(src_pred),
        .src_finished(src_finished),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
        .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op), .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1),
        .ibuf_rs2(ibuf_rs2), .ibuf_imm(ibuf_imm), .ibuf_pred(ibuf_pred),
        .flush(flush), .occupancy(occupancy), .finished(finished)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per warp plus the sticky finish flags.
    ibuf_entry_t mq [NW][$];
    bit seen = 0, fin = 0, model_ok = 0;

    function automatic ibuf_entry_t make_entry(input logic [31:0] pc);
        return pack_entry(pc, pc[6:0] ^ 7'h55, pc[7:0] + 8'd1, pc[7:0] + 8'd2,
                          pc[7:0] + 8'd3, ~pc, pc[3:0]);
    endfunction

    function automatic ibuf_entry_t rand_entry();
        return pack_entry($urandom, 7'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), $urandom, 4'($urandom));
    endfunction

    function automatic ibuf_entry_t out_entry(input int w);
        return pack_entry(ibuf_pc[ARCH_LEN*w +: ARCH_LEN], ibuf_op[OP_BITS*w +: OP_BITS],
                          ibuf_rd[REG_BITS*w +: REG_BITS], ibuf_rs1[REG_BITS*w +: REG_BITS],
                          ibuf_rs2[REG_BITS*w +: REG_BITS], ibuf_imm[IMM_BITS*w +: IMM_BITS],
                          ibuf_pred[PRED_BITS*w +: PRED_BITS]);
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        src_valid    = '0;
        ibuf_ready   = '0;
        flush        = '0;
        src_finished = 1'b0;
    endtask

    // Check against the model, take one clock edge, then advance the model.
    task automatic cycle();
        logic [NW-1:0]    esr, eiv;
        logic [CB*NW-1:0] eocc;
        bit allz;
        #1;
        for (int w = 0; w < NW; w++) begin
            esr[w] = !flush[w] && (reset || mq[w].size() < DEPTH);
            eiv[w] = !reset && !flush[w] && mq[w].size() > 0;
            eocc[CB*w +: CB] = CB'(mq[w].size());
        end
        chk("src_ready", 128'(src_ready), 128'(esr));
        chk("ibuf_valid", 128'(ibuf_valid), 128'(eiv));
        if (model_ok && !reset) begin
            chk("occupancy", 128'(occupancy), 128'(eocc));
            chk("finished", 128'(finished), 128'(fin));
        end
        for (int w = 0; w < NW; w++)
            if (eiv[w]) chk($sformatf("head_w%0d", w), 128'(out_entry(w)), 128'(mq[w][0]));
        @(posedge clock);
        if (reset) begin
            for (int w = 0; w < NW; w++) mq[w].delete();
            seen = 0; fin = 0; model_ok = 1;
        end else begin
            allz = 1;
            for (int w = 0; w < NW; w++) begin
                if (flush[w]) mq[w].delete();
                else begin
                    if (eiv[w] && ibuf_ready[w]) void'(mq[w].pop_front());
                    if (src_valid[w] && esr[w]) mq[w].push_back(in_e[w]);
                end
                if (mq[w].size() != 0) allz = 0;
            end
            seen = seen || src_finished;
            fin  = fin || (seen && allz);
        end
        #1;
    endtask

    typedef struct {
        int          w;
        bit          v;
        logic [31:0] pc;
        bit          rdy;
        bit          e_sr;
        bit          e_iv;
        logic [31:0] e_pc;
        int          e_occ;
    } vec_t;
    vec_t tbl[$];

    initial begin
        for (int w = 0; w < NW; w++) in_e[w] = make_entry(32'(w));
        idle();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;

        // Basic in-order flow on warp 0, then fill/stall/drain on warp 3.
        tbl.push_back('{0, 1, 32'h100, 1, 1, 0, 32'h0,   0});
        tbl.push_back('{0, 1, 32'h104, 1, 1, 1, 32'h100, 1});
        tbl.push_back('{0, 1, 32'h108, 1, 1, 1, 32'h104, 1});
        tbl.push_back('{0, 0, 32'h0,   1, 1, 1, 32'h108, 1});
        tbl.push_back('{0, 0, 32'h0,   1, 1, 0, 32'h0,   0});
        tbl.push_back('{3, 1, 32'h300, 0, 1, 0, 32'h0,   0});
        tbl.push_back('{3, 1, 32'h304, 0, 1, 1, 32'h300, 1});
        tbl.push_back('{3, 1, 32'h308, 0, 1, 1, 32'h300, 2});
        tbl.push_back('{3, 1, 32'h30c, 0, 1, 1, 32'h300, 3});
        tbl.push_back('{3, 1, 32'h310, 0, 0, 1, 32'h300, 4});
        tbl.push_back('{3, 1, 32'h310, 1, 0, 1, 32'h300, 4});
        tbl.push_back('{3, 0, 32'h0,   0, 1, 1, 32'h304, 3});
        tbl.push_back('{3, 0, 32'h0,   1, 1, 1, 32'h304, 3});
        tbl.push_back('{3, 0, 32'h0,   1, 1, 1, 32'h308, 2});
        tbl.push_back('{3, 0, 32'h0,   1, 1, 1, 32'h30c, 1});
        tbl.push_back('{3, 0, 32'h0,   1, 1, 0, 32'h0,   0});
        foreach (tbl[i]) begin
            idle();
            src_valid[tbl[i].w]  = tbl[i].v;
            ibuf_ready[tbl[i].w] = tbl[i].rdy;
            in_e[tbl[i].w]       = make_entry(tbl[i].pc);
            #1;
            chk($sformatf("tbl%0d_src_ready", i), 128'(src_ready[tbl[i].w]), 128'(tbl[i].e_sr));
            chk($sformatf("tbl%0d_ibuf_valid", i), 128'(ibuf_valid[tbl[i].w]), 128'(tbl[i].e_iv));
            if (tbl[i].e_iv)
                chk($sformatf("tbl%0d_pc", i), 128'(ibuf_pc[32*tbl[i].w +: 32]), 128'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_occ", i), 128'(occupancy[CB*tbl[i].w +: CB]), 128'(tbl[i].e_occ));
            cycle();
        end

        // Warp 1 held at two entries while enqueue and dequeue overlap past a wrap.
        idle();
        src_valid[1] = 1'b1;
        in_e[1] = make_entry(32'h1000); cycle();
        in_e[1] = make_entry(32'h1004); cycle();
        for (int k = 0; k < 10; k++) begin
            src_valid[1] = 1'b1; ibuf_ready[1] = 1'b1;
            in_e[1] = make_entry(32'h1008 + 32'(4 * k));
            #1;
            chk("simul_occ", 128'(occupancy[CB*1 +: CB]), 128'(2));
            chk("simul_head", 128'(ibuf_pc[32*1 +: 32]), 128'(32'h1000 + 32'(4 * k)));
            cycle();
        end
        idle(); ibuf_ready[1] = 1'b1; cycle(); cycle();

        // Flush warp 2 (3 entries) while it offers more; warp 5 (2 entries) untouched.
        idle();
        for (int k = 0; k < 3; k++) begin
            src_valid[2] = 1'b1; src_valid[5] = (k < 2);
            in_e[2] = make_entry(32'h2000 + 32'(4 * k));
            in_e[5] = make_entry(32'h5000 + 32'(4 * k));
            cycle();
        end
        idle(); flush[2] = 1'b1; src_valid[2] = 1'b1; in_e[2] = make_entry(32'h2ff0);
        cycle();
        idle(); #1;
        chk("flush_occ2", 128'(occupancy[CB*2 +: CB]), 128'(0));
        chk("flush_valid2", 128'(ibuf_valid[2]), 128'(0));
        chk("flush_occ5", 128'(occupancy[CB*5 +: CB]), 128'(2));
        chk("flush_head5", 128'(ibuf_pc[32*5 +: 32]), 128'(32'h5000));
        cycle();
        ibuf_ready[5] = 1'b1; cycle(); cycle();

        // Reset mid-stream with every warp holding two entries and finish latched.
        idle(); src_valid = '1;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < NW; w++) in_e[w] = rand_entry();
            cycle();
        end
        idle(); src_finished = 1'b1; cycle();
        idle(); #1;
        chk("pre_reset_occ", 128'(occupancy), 128'({NW{CB'(2)}}));
        reset = 1'b1; cycle();
        reset = 1'b0; #1;
        chk("rst_valid", 128'(ibuf_valid), 128'(0));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_finished", 128'(finished), 128'(0));
        cycle(); cycle(); cycle();
        chk("rst_seen_cleared", 128'(finished), 128'(0));

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < NW; w++) begin
                src_valid[w]  = 1'($urandom_range(0, 1));
                ibuf_ready[w] = ($urandom_range(0, 2) != 0);
                flush[w]      = ($urandom_range(0, 31) == 0);
                in_e[w]       = rand_entry();
            end
            src_finished = 1'b0;
            cycle();
        end
        idle(); reset = 1'b1; cycle(); reset = 1'b0;

        // Finish only after warps 0 and 4 drain, then it holds.
        src_valid[0] = 1'b1; src_valid[4] = 1'b1;
        in_e[0] = make_entry(32'h700); in_e[4] = make_entry(32'h740);
        cycle();
        idle(); src_finished = 1'b1; cycle();
        idle();
        for (int k = 0; k < 2; k++) begin
            #1; chk("fin_wait", 128'(finished), 128'(0)); cycle();
        end
        ibuf_ready[0] = 1'b1; cycle();
        idle(); #1; chk("fin_one_left", 128'(finished), 128'(0));
        ibuf_ready[4] = 1'b1; cycle();
        idle(); #1; chk("fin_set", 128'(finished), 128'(1));
        for (int k = 0; k < 3; k++) begin
            cycle(); chk("fin_hold", 128'(finished), 128'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
